// File: rtl/vga_fb_reader.sv
// 640x480@60 VGA raster reader: generates timing, reads RGB444 from the frame-buffer BRAM port, drives DAC pins.
// Build macro TEST_PATTERN_EN adds the i_pattern input and an 8-bar colour test pattern.
module vga_fb_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
`ifdef TEST_PATTERN_EN
    input  logic        i_pattern,
`endif
    output logic [18:0] o_rd_addr,
    output logic        o_rd_en,
    input  logic [11:0] i_rd_data,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]  H_LAST    = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOT - 1);
    localparam logic [9:0]  HS_BEG    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0] ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Per-pixel control travelling alongside the BRAM read.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
`ifdef TEST_PATTERN_EN
        logic [2:0] bar;
`endif
    } tap_t;

    localparam int TW = $bits(tap_t);
    localparam int SW = RD_LAT * TW;

    state_t      state, state_nxt;
    logic [9:0]  h_cnt, h_nxt, v_cnt, v_nxt;
    logic [18:0] addr_nxt;
    logic        running, active, wrap;
    tap_t        tap_c, tap_d;
    logic [SW-1:0] tap_sr;
    logic [11:0] pix;

    assign running       = (state != IDLE);
    assign active        = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign wrap          = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign o_rd_en       = active;
    assign o_frame_start = running && (h_cnt == '0) && (v_cnt == '0);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        addr_nxt  = o_rd_addr;

        case (state)
            IDLE:    if (i_en) state_nxt = RUN;
            RUN:     if (!i_en) state_nxt = wrap ? IDLE : DRAIN;
            DRAIN:   if (i_en) state_nxt = RUN;
                     else if (wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (running) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end

        // Raster order makes the address a plain incrementer that wraps after the last pixel.
        if (active)
            addr_nxt = (o_rd_addr == ADDR_LAST) ? 19'd0 : o_rd_addr + 19'd1;
        else if (!running || v_cnt >= V_ACT)
            addr_nxt = '0;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            o_rd_addr <= '0;
        end else begin
            state     <= state_nxt;
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            o_rd_addr <= addr_nxt;
        end
    end

    always_comb begin
        tap_c    = '0;
        tap_c.de = active;
        tap_c.hs = running && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        tap_c.vs = running && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
`ifdef TEST_PATTERN_EN
        for (int k = 1; k < 8; k++)
            if (h_cnt >= 10'(k * (H_ACTIVE / 8))) tap_c.bar = 3'(k);
`endif
    end

    // RD_LAT-deep delay so control lines up with the BRAM data at the output register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) tap_sr <= '0;
        else         tap_sr <= SW'({tap_sr, tap_c});
    end

    assign tap_d = tap_sr[SW-1 -: TW];

    always_comb begin
        pix = i_rd_data;
`ifdef TEST_PATTERN_EN
        // Bar index bits map straight onto the white..black colour order.
        if (i_pattern)
            pix = {{4{~tap_d.bar[1]}}, {4{~tap_d.bar[2]}}, {4{~tap_d.bar[0]}}};
`endif
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_de                     <= 1'b0;
            o_hsync                  <= ~SYNC_POL;
            o_vsync                  <= ~SYNC_POL;
            {o_red, o_green, o_blue} <= '0;
        end else begin
            o_de                     <= tap_d.de;
            o_hsync                  <= tap_d.hs ? SYNC_POL : ~SYNC_POL;
            o_vsync                  <= tap_d.vs ? SYNC_POL : ~SYNC_POL;
            {o_red, o_green, o_blue} <= tap_d.de ? pix : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: full-size timing instance plus reduced-geometry instances at RD_LAT 1..3.
// Optional TEST_PATTERN_EN build also exercises the colour-bar pattern.
module tb_vga_fb_reader;

    localparam int NPIX = 16 * 6;  // reduced geometry: 16x6 visible, 24x10 total

    logic clk = 1'b0;
    logic rstn;
    logic en;
    logic pattern;
    int   cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // ---------------- reduced-geometry instances, RD_LAT = 1, 2, 3 ----------------
    for (genvar g = 1; g <= 3; g++) begin : g_lat
        logic [18:0] rd_addr;
        logic        rd_en;
        logic [11:0] rd_data;
        logic [3:0]  red, green, blue;
        logic        hs, vs, de, fs;
        logic [11:0] bq [g];
        int          de_idx = 0, rd_idx = 0, rd_total = 0, fs_total = 0, vs_falls = 0;
        int          pix_err = 0, addr_err = 0, lat_err = 0, lat_n = 0, rd_rise = 0;
        logic        rd_en_q = 1'b0, de_q = 1'b0, vs_q = 1'b1;

        vga_fb_reader #(
            .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
            .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
            .RD_LAT(g), .SYNC_POL(1'b0)
        ) u_dut (
            .i_clk(clk), .i_rstn(rstn), .i_en(en),
`ifdef TEST_PATTERN_EN
            .i_pattern(pattern),
`endif
            .o_rd_addr(rd_addr), .o_rd_en(rd_en), .i_rd_data(rd_data),
            .o_red(red), .o_green(green), .o_blue(blue),
            .o_hsync(hs), .o_vsync(vs), .o_de(de), .o_frame_start(fs)
        );

        // BRAM model: data = address, valid g clocks after the read.
        always @(posedge clk) begin
            bq[0] <= rd_addr[11:0];
            for (int k = 1; k < g; k++) bq[k] <= bq[k-1];
        end
        assign rd_data = bq[g-1];

        always @(negedge clk) begin
            if (!rstn) begin
                de_idx <= 0;
                rd_idx <= 0;
            end else begin
                if (rd_en) begin
                    if (rd_addr != 19'(rd_idx % NPIX)) addr_err <= addr_err + 1;
                    rd_idx   <= rd_idx + 1;
                    rd_total <= rd_total + 1;
                end
                if (de) begin
                    if (!pattern && {red, green, blue} != 12'(de_idx % NPIX)) pix_err <= pix_err + 1;
                    de_idx <= de_idx + 1;
                end else if ({red, green, blue} != 12'h000) begin
                    pix_err <= pix_err + 1;
                end
                if (rd_en && !rd_en_q) rd_rise <= cyc;
                if (de && !de_q) begin
                    lat_n <= lat_n + 1;
                    if (cyc - rd_rise != g + 1) lat_err <= lat_err + 1;
                end
                if (fs) fs_total <= fs_total + 1;
                if (!vs && vs_q) vs_falls <= vs_falls + 1;
            end
            rd_en_q <= rd_en;
            de_q    <= de;
            vs_q    <= vs;
        end
    end

    // ---------------- full-size instance for real 640x480 line timing ----------------
    logic [18:0] f_rd_addr;
    logic        f_rd_en, f_hs, f_vs, f_de, f_fs;
    logic [3:0]  f_red, f_green, f_blue;
    logic [11:0] fq0, fq1;
    int          f_fall = 0, f_falls = 0, f_period = 0, f_low = 0;
    int          f_run = 0, f_run_last = 0, f_de_idx = 0, f_pix_err = 0;
    logic        f_hs_q = 1'b1;

    vga_fb_reader u_full (
        .i_clk(clk), .i_rstn(rstn), .i_en(en),
`ifdef TEST_PATTERN_EN
        .i_pattern(pattern),
`endif
        .o_rd_addr(f_rd_addr), .o_rd_en(f_rd_en), .i_rd_data(fq1),
        .o_red(f_red), .o_green(f_green), .o_blue(f_blue),
        .o_hsync(f_hs), .o_vsync(f_vs), .o_de(f_de), .o_frame_start(f_fs)
    );

    always @(posedge clk) begin
        fq0 <= f_rd_addr[11:0];
        fq1 <= fq0;
    end

    always @(negedge clk) begin
        if (!rstn) begin
            f_de_idx <= 0;
            f_run    <= 0;
        end else begin
            if (!f_hs && f_hs_q) begin
                if (f_falls > 0) f_period <= cyc - f_fall;
                f_fall  <= cyc;
                f_falls <= f_falls + 1;
            end
            if (f_hs && !f_hs_q) f_low <= cyc - f_fall;
            if (f_de) begin
                f_run    <= f_run + 1;
                f_de_idx <= f_de_idx + 1;
                if (!pattern && {f_red, f_green, f_blue} != 12'(f_de_idx)) f_pix_err <= f_pix_err + 1;
            end else begin
                if (f_run > 0) f_run_last <= f_run;
                f_run <= 0;
            end
        end
        f_hs_q <= f_hs;
    end

    task automatic wait_fs(input string tag);
        int n = 0;
        while (g_lat[2].fs !== 1'b1 && n < 400) begin
            step(1);
            n++;
        end
        check(tag, g_lat[2].fs, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  g_lat[2].rd_addr, 0);
        check({tag, "_rd_en"}, g_lat[2].rd_en, 0);
        check({tag, "_rgb"},   {g_lat[2].red, g_lat[2].green, g_lat[2].blue}, 0);
        check({tag, "_de"},    g_lat[2].de, 0);
        check({tag, "_fs"},    g_lat[2].fs, 0);
        check({tag, "_hs"},    g_lat[2].hs, 1);
        check({tag, "_vs"},    g_lat[2].vs, 1);
    endtask

    initial begin
        int r0, f0, v0;
        rstn    = 1'b0;
        en      = 1'b0;
        pattern = 1'b0;
        step(3);
        check_reset_outputs("rst");
        check("rst_full_hs", f_hs, 1);

        rstn = 1'b1;
        step(5);
        check("idle_rd_en", g_lat[2].rd_en, 0);
        check("idle_de", g_lat[2].de, 0);
        check("idle_hs", g_lat[2].hs, 1);

        // First frame: frame_start one clock after enable, de RD_LAT+1 clocks after the read.
        en = 1'b1;
        step(1);
        check("first_fs", g_lat[2].fs, 1);
        check("first_rd_en", g_lat[2].rd_en, 1);
        check("first_addr", g_lat[2].rd_addr, 0);
        step(1);
        check("fs_pulse_end", g_lat[2].fs, 0);
        check("second_addr", g_lat[2].rd_addr, 1);
        step(1);
        check("de_not_yet", g_lat[2].de, 0);
        step(1);
        check("de_first", g_lat[2].de, 1);
        check("pix0", {g_lat[2].red, g_lat[2].green, g_lat[2].blue}, 12'h000);
        step(1);
        check("pix1", {g_lat[2].red, g_lat[2].green, g_lat[2].blue}, 12'h001);

        step(2000);
        check("full_hs_falls", f_falls, 2);
        check("full_hs_period", f_period, 800);
        check("full_hs_low", f_low, 96);
        check("full_de_run", f_run_last, 640);
        check("full_pix_err", f_pix_err, 0);
        check("full_vs_idle_level", f_vs, 1);

        // Enable dropped on line 2: frame finishes, then no further reads.
        wait_fs("fs_drop");
        r0 = g_lat[2].rd_total;
        f0 = g_lat[2].fs_total;
        v0 = g_lat[2].vs_falls;
        step(53);
        en = 1'b0;
        step(300);
        check("drop_reads", g_lat[2].rd_total - r0, 95);  // frame_start cycle was already counted
        check("drop_fs", g_lat[2].fs_total - f0, 0);
        check("drop_vsync", g_lat[2].vs_falls - v0, 1);
        check("drop_rd_en", g_lat[2].rd_en, 0);
        check("drop_de", g_lat[2].de, 0);
        check("drop_hs", g_lat[2].hs, 1);

        // Enable drops then returns inside the frame: timing continues without a gap.
        en = 1'b1;
        wait_fs("fs_resume");
        r0 = g_lat[2].rd_total;
        f0 = g_lat[2].fs_total;
        step(53);
        en = 1'b0;
        step(48);
        en = 1'b1;
        step(139);
        check("resume_next_fs", g_lat[2].fs, 1);
        check("resume_reads", g_lat[2].rd_total - r0, 96);
        check("resume_fs", g_lat[2].fs_total - f0, 1);

        // Reset at h=7, v=3 of the reduced raster.
        step(79);
        check("mid_rd_en", g_lat[2].rd_en, 1);
        check("mid_addr", g_lat[2].rd_addr, 55);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step(2);
        rstn = 1'b1;
        step(1);
        check("restart_fs", g_lat[2].fs, 1);
        check("restart_addr0", g_lat[2].rd_addr, 0);
        step(1);
        check("restart_addr1", g_lat[2].rd_addr, 1);

`ifdef TEST_PATTERN_EN
        wait_fs("fs_pattern");
        pattern = 1'b1;
        step(3);
        check("bar_white", {g_lat[2].red, g_lat[2].green, g_lat[2].blue}, 12'hFFF);
        step(2);
        check("bar_yellow", {g_lat[2].red, g_lat[2].green, g_lat[2].blue}, 12'hFF0);
        step(12);
        check("bar_black_de", g_lat[2].de, 1);
        check("bar_black", {g_lat[2].red, g_lat[2].green, g_lat[2].blue}, 12'h000);
        wait_fs("fs_pattern_off");
        pattern = 1'b0;
`endif

        step(300);
        check("pix_err_lat1", g_lat[1].pix_err, 0);
        check("pix_err_lat2", g_lat[2].pix_err, 0);
        check("pix_err_lat3", g_lat[3].pix_err, 0);
        check("addr_err_lat1", g_lat[1].addr_err, 0);
        check("addr_err_lat2", g_lat[2].addr_err, 0);
        check("addr_err_lat3", g_lat[3].addr_err, 0);
        check("de_lat_err1", g_lat[1].lat_err, 0);
        check("de_lat_err2", g_lat[2].lat_err, 0);
        check("de_lat_err3", g_lat[3].lat_err, 0);
        check("de_lat_seen1", g_lat[1].lat_n > 0, 1);
        check("de_lat_seen3", g_lat[3].lat_n > 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #(40 * 50000);
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
